// File: rtl/pkt_rx_frame_buffer_pkg.sv
// Shared receive-path types and constants for the packet frame buffer.
package eth_rx_pkg;

   // One stored buffer entry: payload plus its framing qualifiers.
   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic        err;
   } rx_word_t;

   localparam logic [2:0]  MOD_FULL   = 3'd0;
   localparam int unsigned DROP_CNT_W = 16;

   // Masks the qualifiers of a read word.
   // With val low, everything except data is forced to zero.
   // mod and err are only meaningful on the eop word.
   function automatic rx_word_t qualify_word(input rx_word_t w, input logic val);
      rx_word_t r;
      r      = w;
      r.sop  = val & w.sop;
      r.eop  = val & w.eop;
      r.mod  = (val && w.eop) ? w.mod : MOD_FULL;
      r.err  = val & w.eop & w.err;
      return r;
   endfunction

endpackage

// File: rtl/pkt_rx_frame_buffer_fifo.sv
// Single-clock circular FIFO of rx_word_t entries with a registered read port.
// Occupancy is tracked with an AW+1 bit counter so full and empty stay distinct.
module pkt_rx_fifo
   import eth_rx_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_en,
   input  rx_word_t       wr_word,
   input  logic           rd_en,
   output logic           wr_fire,
   output logic           rd_fire,
   output logic           head_eop,
   output logic           full,
   output logic [AW:0]    count,
   output rx_word_t       rd_word,
   output logic           rd_val
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   rx_word_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            full_q, full_d;
   rx_word_t        rd_word_q, rd_word_d;
   logic            rd_val_q, rd_val_d;

   // Accept/pop qualification and next-state pointer, occupancy and read-port values.
   // Pop decisions use the pre-write occupancy, so a word written this cycle is never read this cycle.
   always_comb begin
      wr_fire   = wr_en & ~full_q;
      rd_fire   = rd_en & (count_q != '0);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rd_word_d = rd_word_q;
      rd_val_d  = rd_fire;
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_fire) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         rd_word_d = mem_q[rd_ptr_q];
      end
      unique case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d = (count_d == DEPTH_C);
   end

   // Storage array, deliberately left without reset.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q] <= wr_word;
      end
   end

   // Pointer, occupancy and read-port registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         rd_word_q <= '0;
         rd_val_q  <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         rd_word_q <= rd_word_d;
         rd_val_q  <= rd_val_d;
      end
   end

   assign head_eop = mem_q[rd_ptr_q].eop;
   assign full     = full_q;
   assign count    = count_q;
   assign rd_word  = rd_word_q;
   assign rd_val   = rd_val_q;

endmodule

// File: rtl/pkt_rx_frame_buffer.sv
// Receive frame buffer.
// Stores framed 64-bit words, tracks the number of complete frames,
// and counts writes rejected while the buffer is full.
module pkt_rx_frame_buffer
   import eth_rx_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                  clk156m25,
   input  logic                  reset_156m25_n,
   input  logic [63:0]           wr_data,
   input  logic                  wr_val,
   input  logic                  wr_sop,
   input  logic                  wr_eop,
   input  logic [2:0]            wr_mod,
   input  logic                  wr_err,
   output logic                  wr_full,
   input  logic                  pkt_rx_ren,
   output logic                  pkt_rx_avail,
   output logic [63:0]           pkt_rx_data,
   output logic                  pkt_rx_val,
   output logic                  pkt_rx_sop,
   output logic                  pkt_rx_eop,
   output logic                  pkt_rx_err,
   output logic [2:0]            pkt_rx_mod,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   rx_word_t                wr_word;
   rx_word_t                rd_word;
   rx_word_t                rd_qual;
   logic                    rd_val;
   logic                    wr_fire;
   logic                    rd_fire;
   logic                    head_eop;
   logic                    fifo_full;
   logic [AW:0]             fifo_count;

   logic [AW:0]             frame_cnt_q, frame_cnt_d;
   logic                    avail_q, avail_d;
   logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   assign wr_word = '{data: wr_data, sop: wr_sop, eop: wr_eop, mod: wr_mod, err: wr_err};

   pkt_rx_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk      (clk156m25),
      .rst_n    (reset_156m25_n),
      .wr_en    (wr_val),
      .wr_word  (wr_word),
      .rd_en    (pkt_rx_ren),
      .wr_fire  (wr_fire),
      .rd_fire  (rd_fire),
      .head_eop (head_eop),
      .full     (fifo_full),
      .count    (fifo_count),
      .rd_word  (rd_word),
      .rd_val   (rd_val)
   );

   // Frame count, avail and saturating drop count next-state.
   // Avail registers the next frame count, so it rises right after the eop word is written.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      unique case ({wr_fire & wr_eop, rd_fire & head_eop})
         2'b10:   frame_cnt_d = frame_cnt_q + 1'b1;
         2'b01:   frame_cnt_d = frame_cnt_q - 1'b1;
         default: frame_cnt_d = frame_cnt_q;
      endcase
      avail_d    = (frame_cnt_d != '0);
      drop_cnt_d = drop_cnt_q;
      if (wr_val && fifo_full && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   // Frame-level state registers with synchronous active-low reset.
   always_ff @(posedge clk156m25) begin
      if (!reset_156m25_n) begin
         frame_cnt_q <= '0;
         avail_q     <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         avail_q     <= avail_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Qualify the registered read word; data holds its last value while val is low.
   always_comb begin
      rd_qual = qualify_word(rd_word, rd_val);
   end

   assign wr_full      = fifo_full;
   assign pkt_rx_avail = avail_q;
   assign pkt_rx_data  = rd_qual.data;
   assign pkt_rx_val   = rd_val;
   assign pkt_rx_sop   = rd_qual.sop;
   assign pkt_rx_eop   = rd_qual.eop;
   assign pkt_rx_err   = rd_qual.err;
   assign pkt_rx_mod   = rd_qual.mod;
   assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_pkt_rx_frame_buffer.sv
// Self-checking bench for pkt_rx_frame_buffer.
// The reference model is a queue of stored words.
// Frames available = number of eop words held.
module tb_pkt_rx_frame_buffer;

   localparam int unsigned DEPTH = 64;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic        err;
   } m_word_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] wr_data;
   logic        wr_val, wr_sop, wr_eop, wr_err;
   logic [2:0]  wr_mod;
   logic        wr_full;
   logic        ren;
   logic        avail;
   logic [63:0] rx_data;
   logic        rx_val, rx_sop, rx_eop, rx_err;
   logic [2:0]  rx_mod;
   logic [15:0] drop_cnt;

   int unsigned total = 0;
   int unsigned bad   = 0;

   m_word_t     mq[$];
   logic [63:0] m_last;
   logic [15:0] m_drop;
   logic        e_val, e_sop, e_eop, e_err, e_full, e_avail;
   logic [2:0]  e_mod;

   always #5 clk = ~clk;

   pkt_rx_frame_buffer #(.DEPTH(DEPTH)) dut (
      .clk156m25      (clk),
      .reset_156m25_n (rst_n),
      .wr_data        (wr_data),
      .wr_val         (wr_val),
      .wr_sop         (wr_sop),
      .wr_eop         (wr_eop),
      .wr_mod         (wr_mod),
      .wr_err         (wr_err),
      .wr_full        (wr_full),
      .pkt_rx_ren     (ren),
      .pkt_rx_avail   (avail),
      .pkt_rx_data    (rx_data),
      .pkt_rx_val     (rx_val),
      .pkt_rx_sop     (rx_sop),
      .pkt_rx_eop     (rx_eop),
      .pkt_rx_err     (rx_err),
      .pkt_rx_mod     (rx_mod),
      .drop_cnt       (drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned frames_held();
      int unsigned n = 0;
      foreach (mq[i]) if (mq[i].eop) n++;
      return n;
   endfunction

   // One clock cycle: drive inputs, update the model, check all outputs after the edge.
   task automatic step(input logic rn, input logic wv, input logic s, input logic e,
                       input logic [2:0] m, input logic er, input logic [63:0] d, input logic rr);
      m_word_t w, p;
      logic    was_full, pop;
      rst_n = rn; wr_val = wv; wr_sop = s; wr_eop = e; wr_mod = m; wr_err = er;
      wr_data = d; ren = rr;
      if (!rn) begin
         mq.delete();
         m_last = '0; m_drop = '0;
         e_val = 0; e_sop = 0; e_eop = 0; e_err = 0; e_mod = 0;
      end else begin
         was_full = (mq.size() == DEPTH);
         pop      = rr && (mq.size() != 0);
         p        = '0;
         if (wv && was_full && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
         if (pop) begin
            p = mq.pop_front();
            m_last = p.data;
         end
         if (wv && !was_full) begin
            w = '{data: d, sop: s, eop: e, mod: m, err: er};
            mq.push_back(w);
         end
         e_val = pop;
         e_sop = pop & p.sop;
         e_eop = pop & p.eop;
         e_mod = (pop && p.eop) ? p.mod : 3'd0;
         e_err = pop & p.eop & p.err;
      end
      e_full  = (mq.size() == DEPTH);
      e_avail = (frames_held() != 0);
      @(posedge clk);
      #1;
      chk("val",   {63'd0, rx_val},   {63'd0, e_val});
      chk("data",  rx_data,           m_last);
      chk("sop",   {63'd0, rx_sop},   {63'd0, e_sop});
      chk("eop",   {63'd0, rx_eop},   {63'd0, e_eop});
      chk("mod",   {61'd0, rx_mod},   {61'd0, e_mod});
      chk("err",   {63'd0, rx_err},   {63'd0, e_err});
      chk("full",  {63'd0, wr_full},  {63'd0, e_full});
      chk("avail", {63'd0, avail},    {63'd0, e_avail});
      chk("drop",  {48'd0, drop_cnt}, {48'd0, m_drop});
   endtask

   task automatic wr(input logic s, input logic e, input logic [2:0] m, input logic er, input logic [63:0] d);
      step(1, 1, s, e, m, er, d, 0);
   endtask

   task automatic rd();
      step(1, 0, 0, 0, 3'd0, 0, 64'd0, 1);
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 3'd0, 0, 64'd0, 0);
   endtask

   initial begin
      int unsigned wp, rp;
      // reset state
      step(0, 0, 0, 0, 3'd0, 0, 64'd0, 0);
      step(0, 0, 0, 0, 3'd0, 0, 64'd0, 0);
      idle();

      // 3-word frame, mod=5, then three consecutive reads
      wr(1, 0, 3'd0, 0, 64'h1111_0000_0000_0001);
      wr(0, 0, 3'd0, 0, 64'h2222_0000_0000_0002);
      wr(0, 1, 3'd5, 0, 64'h3333_0000_0000_0003);
      rd(); rd(); rd();
      idle();

      // ren held on empty buffer, then confirm pointers still aligned
      repeat (4) rd();
      wr(1, 1, 3'd3, 1, 64'hA5A5_5A5A_0F0F_F0F0);
      rd();
      idle();

      // fill with 64 non-eop words, then a 65th dropped
      for (int i = 0; i < 64; i++) wr(i == 0, 0, 3'd0, 0, 64'h0100 + 64'(i));
      wr(0, 1, 3'd2, 0, 64'hDEAD_BEEF_0000_0041);
      // full buffer: simultaneous write and read
      step(1, 1, 0, 1, 3'd1, 1, 64'hBAD0_BAD0_BAD0_BAD0, 1);
      // one free slot: accepted, full again
      wr(0, 1, 3'd7, 1, 64'hFEED_0000_0000_0042);
      for (int i = 0; i < 65; i++) rd();
      idle();

      // two 1-word frames, then eop write + eop read in the same cycle
      wr(1, 1, 3'd1, 0, 64'h0000_0000_0000_00F1);
      wr(1, 1, 3'd6, 1, 64'h0000_0000_0000_00F2);
      step(1, 1, 1, 1, 3'd4, 0, 64'h0000_0000_0000_00F3, 1);
      idle();
      rd(); rd(); rd(); rd();
      idle();

      // reset during a frame read, then a clean frame
      wr(1, 0, 3'd0, 0, 64'h7000_0000_0000_0001);
      wr(0, 0, 3'd0, 0, 64'h7000_0000_0000_0002);
      wr(0, 1, 3'd2, 1, 64'h7000_0000_0000_0003);
      rd();
      step(0, 0, 0, 0, 3'd0, 0, 64'd0, 1);
      rd();
      wr(1, 0, 3'd0, 0, 64'h8000_0000_0000_0001);
      wr(0, 1, 3'd0, 0, 64'h8000_0000_0000_0002);
      rd(); rd(); rd();
      idle();

      // randomized traffic with phase-dependent write/read bias
      for (int ph = 0; ph < 8; ph++) begin
         wp = (ph % 2 == 0) ? 85 : 30;
         rp = (ph % 2 == 0) ? 25 : 80;
         for (int c = 0; c < 300; c++) begin
            step(($urandom_range(0, 599) != 0),
                 ($urandom_range(0, 99) < wp),
                 1'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom), 1'($urandom),
                 {$urandom, $urandom},
                 ($urandom_range(0, 99) < rp));
         end
      end
      for (int i = 0; i < 70; i++) rd();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
